// File: rtl/simple_cpu_sequencer_pkg.sv
// rtl/simple_cpu_sequencer_pkg.sv - shared class codes, state encodings and widths for the sequencer
package simple_cpu_sequencer_pkg;

  localparam int DEF_INSTR_WIDTH = 20;
  localparam int DEF_PC_BITS     = 5;
  localparam int CNT_BITS        = 8;

  typedef enum logic [1:0] {
    CLS_HALT  = 2'b00,
    CLS_ALU   = 2'b01,
    CLS_LOAD  = 2'b10,
    CLS_STORE = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Counter preload is N-1 so that the cnt==0 cycle is the last of N hold cycles.
  function automatic logic [CNT_BITS-1:0] hold_last(input cls_e cls, input int alu_n,
                                                    input int load_n, input int store_n);
    case (cls)
      CLS_LOAD:  return CNT_BITS'(load_n - 1);
      CLS_STORE: return CNT_BITS'(store_n - 1);
      default:   return CNT_BITS'(alu_n - 1);
    endcase
  endfunction

endpackage

// File: rtl/simple_cpu_sequencer_if.sv
// rtl/simple_cpu_sequencer_if.sv - host-facing program-load, control and instruction bus
interface simple_cpu_sequencer_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
);
  logic                   prog_we;
  logic [PC_BITS-1:0]     prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic                   start;
  logic                   halt_req;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [PC_BITS-1:0]     pc;
  logic                   busy;
  logic                   done;

  modport master (
    output prog_we, prog_addr, prog_data, start, halt_req,
    input  instr_out, pc, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, halt_req,
    output instr_out, pc, busy, done
  );
endinterface

// File: rtl/simple_cpu_sequencer_prog_mem.sv
// rtl/simple_cpu_sequencer_prog_mem.sv - program memory, one write port, one synchronous write-first read port
module sc_prog_mem #(
  parameter int DW = 20,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  // Contents survive reset so a program can be rerun after a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/simple_cpu_sequencer.sv
// rtl/simple_cpu_sequencer.sv - fetches program words and holds each on instr_out for its class cycle count
module simple_cpu_sequencer
  import simple_cpu_sequencer_pkg::*;
#(
  parameter int INSTR_WIDTH  = DEF_INSTR_WIDTH,
  parameter int PC_BITS      = DEF_PC_BITS,
  parameter int ALU_CYCLES   = 3,
  parameter int LOAD_CYCLES  = 4,
  parameter int STORE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  simple_cpu_sequencer_if.slave bus
);
  localparam logic [PC_BITS-1:0] PC_LAST = {PC_BITS{1'b1}};

  state_e                 state;
  logic [PC_BITS-1:0]     pc_r;
  logic [INSTR_WIDTH-1:0] instr_r;
  logic [CNT_BITS-1:0]    cnt;
  logic                   busy_r;
  logic                   done_r;
  logic [INSTR_WIDTH-1:0] rdata;
  logic                   mem_we;
  cls_e                   cls;

  assign mem_we = bus.prog_we && !busy_r;
  assign cls    = cls_e'(rdata[INSTR_WIDTH-1 -: 2]);

  sc_prog_mem #(
    .DW(INSTR_WIDTH),
    .AW(PC_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (pc_r),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc_r    <= '0;
      instr_r <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            pc_r   <= '0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (cls == CLS_HALT) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= S_DONE;
          end else begin
            instr_r <= rdata;
            cnt     <= hold_last(cls, ALU_CYCLES, LOAD_CYCLES, STORE_CYCLES);
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            // Dropping to zero here yields the two no-op bubbles through FETCH/DECODE.
            instr_r <= '0;
            if (bus.halt_req || (pc_r == PC_LAST)) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= S_DONE;
            end else begin
              pc_r  <= pc_r + 1'b1;
              state <= S_FETCH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          instr_r <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_out = instr_r;
  assign bus.pc        = pc_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule
